// File: rtl/trace_capture.sv
// trace_capture: commit-event tracer for the riscv core side-band outputs.
// Captures register write-backs and data-memory accesses, stamps each with a
// free-running cycle count, buffers them in a FIFO and drains them over a
// valid/ready stream. Up to two events (REG then MEM) are accepted per cycle.
// Optional build macro: TRACE_FILTER_X0_EN -- when defined, writes to x0 are
// discarded before the FIFO and are not counted as drops.
module trace_capture #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [31:0]              reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [8:0]               addr,
    input  logic [31:0]              wr_data,
    input  logic [31:0]              rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [8:0]               out_idx,
    output logic [31:0]              out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 2 + 9 + 32 + TS_W;

    localparam logic [1:0] KIND_REG  = 2'b00;
    localparam logic [1:0] KIND_MEMW = 2'b01;
    localparam logic [1:0] KIND_MEMR = 2'b10;

    logic [TS_W-1:0] ts_q;
    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            ev_reg;
    logic            ev_mem;
    logic            pop;
    logic [1:0]      need;
    logic [LW-1:0]   free;
    logic [1:0]      n_push;
    logic [1:0]      n_drop;
    logic [RW-1:0]   rec_reg;
    logic [RW-1:0]   rec_mem;
    logic [RW-1:0]   rec0;
    logic [RW-1:0]   head_next;
    logic [AW-1:0]   wr_ptr1;
    logic [AW-1:0]   rd_next;
    logic [LW-1:0]   level_next;
    logic [8:0]      drop_sum;

`ifdef TRACE_FILTER_X0_EN
    assign ev_reg = reg_write_sig & (reg_num != 5'd0);
`else
    assign ev_reg = reg_write_sig;
`endif

    // simultaneous wr and rd is illegal and produces no memory event
    assign ev_mem    = wr ^ rd;
    assign out_valid = (level != '0);

    // event formatting, space check, push/drop split and next-head selection
    always_comb begin
        rec_reg = {KIND_REG, 4'b0000, reg_num, reg_data, ts_q};
        rec_mem = {(wr ? KIND_MEMW : KIND_MEMR), addr, (wr ? wr_data : rd_data), ts_q};
        rec0    = ev_reg ? rec_reg : rec_mem;

        pop  = out_valid & out_ready;
        need = {1'b0, ev_reg} + {1'b0, ev_mem};
        free = LW'(DEPTH) - level + LW'(pop);

        // with only one free slot the REG record (written first) wins
        if (free >= LW'(need))
            n_push = need;
        else
            n_push = free[1:0];
        n_drop = need - n_push;

        wr_ptr1    = wr_ptr + 1'b1;
        rd_next    = rd_ptr + AW'(pop);
        level_next = level - LW'(pop) + LW'(n_push);

        // a FIFO that is empty after this cycle's pop takes its new head from
        // the record being written now, since storage is not yet updated
        if (level == LW'(pop))
            head_next = rec0;
        else
            head_next = mem[rd_next];

        drop_sum = {1'b0, drop_cnt} + 9'(n_drop);
    end

    // record storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (n_push != 2'd0)
            mem[wr_ptr] <= rec0;
        if (n_push == 2'd2)
            mem[wr_ptr1] <= rec_mem;
    end

    // timestamp, pointers, occupancy and saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            ts_q     <= ts_q + 1'b1;
            wr_ptr   <= wr_ptr + AW'(n_push);
            rd_ptr   <= rd_next;
            level    <= level_next;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // registered head record; holds its last value while the FIFO is empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_kind <= '0;
            out_idx  <= '0;
            out_data <= '0;
            out_ts   <= '0;
        end else if (level_next != '0) begin
            {out_kind, out_idx, out_data, out_ts} <= head_next;
        end
    end

endmodule
